// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with a single outstanding memory read
//
// Fetches one instruction word per pc_update and hands it to decode over a
// valid/ready handshake. At most one instruction memory read is ever in flight;
// a redirect that arrives while a read is pending drains the stale response first.
//
// Parameters:
//   ROM_BASE  byte address of instruction memory word 0
//   ADDR_W    instruction memory word-address width (2^ADDR_W words)
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   addr, pc_update             fetch byte address and its one-cycle request pulse
//   imem_req, imem_addr         one-cycle read strobe and word address to memory
//   imem_rdata, imem_rvalid     read data and its one-cycle valid pulse
//   instr, pc_out               fetched instruction and its byte address
//   instr_valid, instr_ready    handshake to decode
//   fetch_fault                 rejected fetch address
//   busy                        a fetch is in progress (REQ, WAIT or DRAIN)
// Build option:
//   IFETCH_FAULT_CHECK_EN       reject misaligned or out-of-ROM fetch addresses
module instr_fetch #(
    parameter logic [31:0] ROM_BASE = 32'h01000000,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic              pc_update,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_rvalid,
    output logic [31:0]       instr,
    output logic [31:0]       pc_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_fault,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        HOLD,
        FAULT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] fa;
    logic [31:0] fa_next;
    logic        next_ok;

    // Every decision in this cycle that leads to REQ uses the address that
    // will be in fa after this edge, so a same-cycle pc_update is honoured.
    assign fa_next = pc_update ? addr : fa;

`ifdef IFETCH_FAULT_CHECK_EN
    localparam logic [32:0] ROM_BYTES = 33'd4 << ADDR_W;

    logic [32:0] fa_off;

    // 33-bit subtraction: bit 32 set means fa_next lies below ROM_BASE.
    assign fa_off  = {1'b0, fa_next} - {1'b0, ROM_BASE};
    assign next_ok = (fa_next[1:0] == 2'b00) && !fa_off[32] && (fa_off < ROM_BYTES);
`else
    assign next_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, FAULT: begin
                if (pc_update) state_next = next_ok ? REQ : FAULT;
            end
            HOLD: begin
                // A redirect wins over a simultaneous acceptance.
                if (pc_update)        state_next = next_ok ? REQ : FAULT;
                else if (instr_ready) state_next = IDLE;
            end
            REQ: begin
                // The strobe has not left yet, so a redirect simply retargets it.
                if (pc_update) state_next = next_ok ? REQ : FAULT;
                else           state_next = WAIT;
            end
            WAIT: begin
                if (pc_update && imem_rvalid) state_next = next_ok ? REQ : FAULT;
                else if (pc_update)           state_next = DRAIN;
                else if (imem_rvalid)         state_next = HOLD;
            end
            DRAIN: begin
                // The outstanding response is stale; only after it lands may a new read go out.
                if (imem_rvalid) state_next = next_ok ? REQ : FAULT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fa          <= ROM_BASE;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr       <= '0;
            pc_out      <= ROM_BASE;
            instr_valid <= 1'b0;
        end else begin
            fa          <= fa_next;
            imem_req    <= (state == REQ) && (state_next == WAIT);
            instr_valid <= (state_next == HOLD);
            if ((state == REQ) && (state_next == WAIT)) begin
                imem_addr <= ADDR_W'((fa - ROM_BASE) >> 2);
            end
            if ((state == WAIT) && imem_rvalid && !pc_update) begin
                instr  <= imem_rdata;
                pc_out <= fa;
            end
        end
    end

`ifdef IFETCH_FAULT_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_fault <= 1'b0;
        end else begin
            fetch_fault <= (state_next == FAULT);
        end
    end
`else
    assign fetch_fault = 1'b0;
`endif

    assign busy = (state == REQ) || (state == WAIT) || (state == DRAIN);

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ROM_BASE, default 32'h01000000, SHALL be the byte address of instruction memory word 0.
REQ-002 Parameter ADDR_W, default 10, SHALL be the instruction memory word-address width, giving 2^ADDR_W words.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 addr  input  32  SHALL carry the byte address from the program counter.
REQ-006 pc_update  input  1  SHALL be a one-cycle pulse requesting a fetch at addr.
REQ-007 imem_req  output  1  SHALL be a one-cycle read strobe to instruction memory.
REQ-008 imem_addr  output  ADDR_W  SHALL be the word address, (addr - ROM_BASE) >> 2, truncated to ADDR_W bits.
REQ-009 imem_rdata  input  32  SHALL carry read data, valid only when imem_rvalid is high.
REQ-010 imem_rvalid  input  1  SHALL pulse exactly once per imem_req, one or more cycles after it.
REQ-011 instr, pc_out  output  32 each  SHALL carry the fetched instruction and its byte address.
REQ-012 instr_valid  output  1; instr_ready  input  1  SHALL form the valid/ready handshake to decode.
REQ-013 fetch_fault  output  1  SHALL flag a rejected fetch address.
REQ-014 busy  output  1  SHALL be high in every state except IDLE, HOLD and FAULT.

Function
REQ-015 States SHALL be IDLE, REQ, WAIT, DRAIN, HOLD and FAULT.
REQ-016 pc_update SHALL latch addr into the internal register fa in the same edge, in every state.
REQ-017 pc_update in IDLE, HOLD or FAULT SHALL go to REQ, or to FAULT if fa is illegal.
REQ-018 REQ SHALL assert imem_req for exactly one cycle with imem_addr taken from fa, then go to WAIT.
REQ-019 WAIT with imem_rvalid and no pc_update SHALL register instr = imem_rdata and pc_out = fa, then go to HOLD.
REQ-020 Minimum latency SHALL be 3 cycles: pc_update at edge N gives imem_req at N+1, and imem_rvalid at N+2 gives instr_valid at N+3.
REQ-021 HOLD SHALL assert instr_valid, with instr and pc_out stable, until instr_ready is sampled high; it then goes to IDLE.
REQ-022 pc_update in HOLD SHALL drop the held instruction; instr_valid goes low the next cycle whatever instr_ready is.
REQ-023 pc_update in WAIT without imem_rvalid SHALL go to DRAIN.
REQ-024 DRAIN SHALL discard the next imem_rvalid and then go to REQ with the latest fa.
REQ-025 pc_update in DRAIN SHALL only update fa and stay in DRAIN.
REQ-026 pc_update and imem_rvalid together in WAIT SHALL discard the data and go directly to REQ.
REQ-027 FAULT SHALL hold fetch_fault=1, instr_valid=0 and imem_req=0 until the next pc_update.
REQ-028 At most one memory request SHALL ever be outstanding.

Reset
REQ-029 rst SHALL force IDLE, instr=0, pc_out=ROM_BASE, fa=ROM_BASE and all 1-bit outputs to 0 on the next edge.
REQ-030 rst SHALL override pc_update and imem_rvalid.
REQ-031 A response pending at reset SHALL be ignored, and no imem_req is issued until a pc_update after reset.

Configuration
REQ-032 With IFETCH_FAULT_CHECK_EN defined, fa SHALL be illegal if fa[1:0]!=0, fa<ROM_BASE, or fa-ROM_BASE >= 4*2^ADDR_W.
REQ-033 Without IFETCH_FAULT_CHECK_EN, every fa SHALL be legal, FAULT is unreachable and fetch_fault is tied to 0.

Verification
REQ-034 Reset, then pc_update with addr=32'h01000008 and rvalid one cycle after req -> imem_addr=2; instr_valid at N+3; pc_out=32'h01000008.
REQ-035 Hold instr_ready=0 for 5 cycles in HOLD -> instr and pc_out stable throughout; the handshake completes on the first ready=1.
REQ-036 pc_update to 32'h01000010 in WAIT, with rvalid 2 cycles later -> first data discarded; second imem_req has imem_addr=4; only the second instr is delivered.
REQ-037 pc_update and imem_rvalid in the same cycle -> no instr_valid; the next cycle is imem_req.
REQ-038 With IFETCH_FAULT_CHECK_EN: addr=32'h01000002 or 32'h00FFFFFC -> fetch_fault=1 and no imem_req; a legal pc_update clears it. Without the macro: no fault and a request is issued.
REQ-039 Assert rst during WAIT -> all outputs reach their reset values the next cycle; a later rvalid produces no instr_valid.
